if_id_inst_queue: RTL and testbench

//   Instruction queue between the fetch stage and the decode stage. Buffers up to DEPTH

---
 rtl/if_id_inst_queue_if.sv | 28 ++
 rtl/if_id_inst_queue.sv | 112 +++++++++++
 tb/tb_if_id_inst_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// slave is the queue side; master is the fetch/decode (or bench) side.
interface if_id_inst_queue_if #(
  parameter int unsigned CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_is_ctrl;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [31:0]      drop_cnt;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst, out_is_ctrl, count, drop_cnt
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst, out_is_ctrl, count, drop_cnt
  );
endinterface

// File: rtl/if_id_inst_queue.sv
// Fetch-to-decode instruction FIFO with control-flow predecode and redirect flush.
// Occupancy is tracked by count; pointers only address storage.
module if_id_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic               clock,
  input logic               reset,
  if_id_inst_queue_if.slave bus_io
);

  localparam int unsigned       PtrW     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DepthCnt = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_ctrl;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      drop_cnt_q, drop_cnt_d;

  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic             in_is_ctrl;
  logic [CNT_W-1:0] discard;
  logic [32:0]      drop_sum;

  // Handshake qualifiers; in_ready deliberately ignores out_ready.
  always_comb begin
    in_ready  = reset & ~bus_io.flush & (count_q < DepthCnt);
    out_valid = (count_q != '0);
    push      = bus_io.in_valid & in_ready;
    pop       = out_valid & bus_io.out_ready;
  end

  // JAL, JALR and BRANCH opcodes.
  always_comb begin
    in_is_ctrl = 1'b0;
    unique case (bus_io.in_inst[6:0])
      7'b1101111,
      7'b1100111,
      7'b1100011: in_is_ctrl = 1'b1;
      default:    in_is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    discard    = count_q - CNT_W'(pop);
    drop_sum   = {1'b0, drop_cnt_q} + 33'(discard);

    if (bus_io.flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end else begin
      if (push) begin
        mem_d[tail_q] = '{pc: bus_io.in_pc, inst: bus_io.in_inst, is_ctrl: in_is_ctrl};
        tail_d        = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head fields are zeroed while empty so decode never sees stale data.
  always_comb begin
    bus_io.in_ready    = in_ready;
    bus_io.out_valid   = out_valid;
    bus_io.out_pc      = out_valid ? mem_q[head_q].pc      : 32'h0;
    bus_io.out_inst    = out_valid ? mem_q[head_q].inst    : 32'h0;
    bus_io.out_is_ctrl = out_valid ? mem_q[head_q].is_ctrl : 1'b0;
    bus_io.count       = count_q;
    bus_io.drop_cnt    = drop_cnt_q;
  end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Self-checking bench for if_id_inst_queue: queue-based reference model compared
// every cycle, plus directed literal expectations.
module tb_if_id_inst_queue;

  localparam int unsigned Depth = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  if_id_inst_queue_if #(.CNT_W(3)) bus ();

  if_id_inst_queue #(
    .DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus_io(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  ent_t        mq[$];
  logic [31:0] m_drop;
  bit          m_ok;
  bit          preset_req;

  function automatic bit is_ctrl_op(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      mq.delete();
      m_drop = 32'h0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      bit      rdy;
      bit      pp;
      bit      ps;
      longint  sum;
      rdy = !bus.flush && (mq.size() < Depth);
      pp  = (mq.size() != 0) && bus.out_ready;
      ps  = bus.in_valid && rdy;
      if (bus.flush) begin
        sum = longint'(m_drop) + longint'(mq.size()) - longint'(pp);
        m_drop = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
        mq.delete();
      end else begin
        if (pp) void'(mq.pop_front());
        if (ps) mq.push_back('{pc: bus.in_pc, inst: bus.in_inst});
      end
      if (preset_req) m_drop = 32'hFFFF_FFFE;
    end
  end

  // Mid-cycle comparison against the model.
  always @(negedge clock) begin
    if (m_ok) begin
      bit e_val;
      e_val = (mq.size() != 0);
      chk("in_ready", 32'(bus.in_ready),
          32'(reset && !bus.flush && (mq.size() < Depth)));
      chk("out_valid", 32'(bus.out_valid), 32'(e_val));
      chk("out_pc", bus.out_pc, e_val ? mq[0].pc : 32'h0);
      chk("out_inst", bus.out_inst, e_val ? mq[0].inst : 32'h0);
      chk("out_is_ctrl", 32'(bus.out_is_ctrl), e_val ? 32'(is_ctrl_op(mq[0].inst)) : 32'h0);
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("drop_cnt", bus.drop_cnt, m_drop);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                       input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog actual timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_ok       = 1'b0;
    preset_req = 1'b0;
    m_drop     = 32'h0;
    reset      = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);

    // 1: reset for three cycles, then release.
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("t1_count", 32'(bus.count), 32'd0);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_out_inst", bus.out_inst, 32'h0);
    chk("t1_drop_cnt", bus.drop_cnt, 32'h0);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);

    // 2: three pushes while decode stalls, then drain in order.
    tick();
    drive(1, 32'h3000_0000, 32'h0000_0013, 0, 0); tick();
    drive(1, 32'h3000_0004, 32'h0000_006F, 0, 0); tick();
    drive(1, 32'h3000_0008, 32'h00A0_0093, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("t2_count", 32'(bus.count), 32'd3);
    chk("t2_head_pc", bus.out_pc, 32'h3000_0000);
    chk("t2_head_ctrl", 32'(bus.out_is_ctrl), 32'd0);
    drive(0, 32'h0, 32'h0, 1, 0); tick();
    #1;
    chk("t2_second_pc", bus.out_pc, 32'h3000_0004);
    chk("t2_second_ctrl", 32'(bus.out_is_ctrl), 32'd1);
    tick();
    #1;
    chk("t2_third_pc", bus.out_pc, 32'h3000_0008);
    chk("t2_third_ctrl", 32'(bus.out_is_ctrl), 32'd0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);

    // 3: fill, refused push while full even with a pop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), (i == 2) ? 32'h0000_0063 : 32'h0000_0013, 0, 0);
      tick();
    end
    drive(1, 32'h110, 32'h0000_0067, 0, 0);
    #1;
    chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_full_count", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("t3_pop_only_count", 32'(bus.count), 32'd3);
    chk("t3_in_ready_again", 32'(bus.in_ready), 32'd1);
    tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    repeat (3) tick();

    // 4: steady push+pop at count 1; pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h200 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7), 1, 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("t4_count", 32'(bus.count), 32'd1);
    chk("t4_head_pc", bus.out_pc, 32'h24C);

    // 5: flush at count 3 with a pop in the same cycle.
    drive(1, 32'h300, 32'h0000_006F, 0, 0); tick();
    drive(1, 32'h304, 32'h0000_0013, 0, 0); tick();
    drive(1, 32'h308, 32'h0000_0013, 1, 1);
    #1;
    chk("t5_flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("t5_drop_cnt", bus.drop_cnt, 32'd2);
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    drive(0, 32'h0, 32'h0, 0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("t5_empty_flush_drop", bus.drop_cnt, 32'd2);

    // 6: saturating drop counter, then mid-operation reset.
    drive(1, 32'h400, 32'h0000_0013, 0, 0);
    force dut.drop_cnt_d = 32'hFFFF_FFFE;
    preset_req = 1'b1;
    tick();
    release dut.drop_cnt_d;
    preset_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(1, 32'h400 + 32'(4 * i), 32'h0000_0013, 0, 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("t6_drop_saturated", bus.drop_cnt, 32'hFFFF_FFFF);
    drive(1, 32'h500, 32'h0000_0013, 0, 0); tick();
    drive(1, 32'h504, 32'h0000_0013, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("t6_count_before_reset", 32'(bus.count), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t6_reset_count", 32'(bus.count), 32'd0);
    chk("t6_reset_drop", bus.drop_cnt, 32'h0);
    chk("t6_reset_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
